// File: rtl/hazard_pkg.sv
// Shared constants and types for the ID-stage hazard controller and its mult/div busy timer.
package hazard_pkg;

  localparam logic     ST_RUN     = 1'b0;
  localparam logic     ST_MD_BUSY = 1'b1;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int       MD_LAT_DEF = 4;

  typedef enum logic {
    RUN     = ST_RUN,
    MD_BUSY = ST_MD_BUSY
  } md_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// ID-stage hazard bus: decode/EX status into the controller, pipeline-register enables back out.
interface hazard_ctrl_if;
  logic [4:0] ifid_rs_i;
  logic [4:0] ifid_rt_i;
  logic       ifid_use_rt_i;
  logic       ifid_use_hilo_i;
  logic       jump_i;
  logic       idex_memread_i;
  logic [4:0] idex_rt_i;
  logic       md_start_i;
  logic       branch_taken_i;
  logic       pc_write_o;
  logic       ifid_write_o;
  logic       ifid_flush_o;
  logic       idex_flush_o;
  logic       md_busy_o;

  modport master (
    output ifid_rs_i, ifid_rt_i, ifid_use_rt_i, ifid_use_hilo_i, jump_i,
           idex_memread_i, idex_rt_i, md_start_i, branch_taken_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, md_busy_o
  );

  modport slave (
    input  ifid_rs_i, ifid_rt_i, ifid_use_rt_i, ifid_use_hilo_i, jump_i,
           idex_memread_i, idex_rt_i, md_start_i, branch_taken_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o, md_busy_o
  );
endinterface

// File: rtl/md_busy_timer.sv
// Tracks how long the multi-cycle mult/div unit holds HI/LO after issue (RUN / MD_BUSY + countdown).
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic md_start_i,
  output logic md_busy_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (md_start_i) begin
            state <= MD_BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        MD_BUSY: begin
          // A new issue restarts the full latency window; otherwise count down without wrapping.
          if (md_start_i) begin
            cnt <= CNT_LOAD;
          end else if (cnt <= CNT_ONE) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign md_busy_o = (state == MD_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// MIPS ID-stage hazard controller: load-use / HI-LO stalls, branch and jump flushes.
// Optional HAZARD_STATS_EN adds saturating stall and flush event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LAT = MD_LAT_DEF,
  parameter int CNT_W  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef HAZARD_STATS_EN
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
`endif
  hazard_ctrl_if.slave bus
);

  logic md_busy_raw;
  logic load_use;
  logic hilo_stall;

  md_busy_timer #(
    .MD_LAT (MD_LAT),
    .CNT_W  (CNT_W)
  ) u_md_busy_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .md_start_i (bus.md_start_i),
    .md_busy_o  (md_busy_raw)
  );

  // A load into $0 never produces a real dependency.
  assign load_use = bus.idex_memread_i && (bus.idex_rt_i != REG_ZERO) &&
                    ((bus.idex_rt_i == bus.ifid_rs_i) ||
                     (bus.ifid_use_rt_i && (bus.idex_rt_i == bus.ifid_rt_i)));

  assign hilo_stall    = md_busy_raw && bus.ifid_use_hilo_i;
  assign bus.md_busy_o = rst_i ? 1'b0 : md_busy_raw;

  always_comb begin
    bus.pc_write_o   = 1'b1;
    bus.ifid_write_o = 1'b1;
    bus.ifid_flush_o = 1'b0;
    bus.idex_flush_o = 1'b0;
    if (rst_i) begin
      bus.pc_write_o   = 1'b0;
      bus.ifid_write_o = 1'b0;
      bus.ifid_flush_o = 1'b1;
      bus.idex_flush_o = 1'b1;
    end else if (bus.branch_taken_i) begin
      bus.ifid_flush_o = 1'b1;
      bus.idex_flush_o = 1'b1;
    end else if (hilo_stall || load_use) begin
      // Hold PC and IF/ID, inject a bubble; a held jump is re-evaluated next cycle.
      bus.pc_write_o   = 1'b0;
      bus.ifid_write_o = 1'b0;
      bus.idex_flush_o = 1'b1;
    end else if (bus.jump_i) begin
      bus.ifid_flush_o = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (!bus.pc_write_o && (stall_cnt_o != 32'hFFFF_FFFF))
        stall_cnt_o <= stall_cnt_o + 32'd1;
      if (bus.ifid_flush_o && (flush_cnt_o != 32'hFFFF_FFFF))
        flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic against a cycle-indexed model.
module tb_hazard_ctrl;
  localparam int MD_LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   last_start = -100;

  hazard_ctrl_if bus ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
`ifdef HAZARD_STATS_EN
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s cyc=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
  endtask

  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic use_rt, input logic hilo, input logic jmp,
                       input logic mrd, input logic [4:0] xrt, input logic mds,
                       input logic br);
    rst                 = r;
    bus.ifid_rs_i       = rs;
    bus.ifid_rt_i       = rt;
    bus.ifid_use_rt_i   = use_rt;
    bus.ifid_use_hilo_i = hilo;
    bus.jump_i          = jmp;
    bus.idex_memread_i  = mrd;
    bus.idex_rt_i       = xrt;
    bus.md_start_i      = mds;
    bus.branch_taken_i  = br;
  endtask

  // Check this cycle's outputs against the rules, then advance one clock and update the model.
  task automatic step(input string tag);
    bit busy, dep, stall;
    logic [3:0] exp;  // {pc_write, ifid_write, ifid_flush, idex_flush}
    @(negedge clk);
    busy  = !rst && (cyc > last_start) && (cyc - last_start <= MD_LAT - 1);
    dep   = bus.idex_memread_i && (bus.idex_rt_i != 0) &&
            (bus.idex_rt_i == bus.ifid_rs_i ||
             (bus.ifid_use_rt_i && bus.idex_rt_i == bus.ifid_rt_i));
    stall = dep || (busy && bus.ifid_use_hilo_i);
    if (rst)                     exp = 4'b0011;
    else if (bus.branch_taken_i) exp = 4'b1111;
    else if (stall)              exp = 4'b0001;
    else if (bus.jump_i)         exp = 4'b1110;
    else                         exp = 4'b1100;
    chk({tag, ".pc_write"},   bus.pc_write_o,   exp[3]);
    chk({tag, ".ifid_write"}, bus.ifid_write_o, exp[2]);
    chk({tag, ".ifid_flush"}, bus.ifid_flush_o, exp[1]);
    chk({tag, ".idex_flush"}, bus.idex_flush_o, exp[0]);
    chk({tag, ".md_busy"},    bus.md_busy_o,    busy);
    @(posedge clk);
    if (rst)                 last_start = -100;
    else if (bus.md_start_i) last_start = cyc;
    cyc++;
    #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reset0");
    drive(1, 0, 0, 0, 1, 1, 1, 5'd3, 1, 0);
    step("reset1");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("post_reset");

    // Load-use on rs: one bubble, then the load has moved on.
    drive(0, 8, 2, 0, 0, 0, 1, 8, 0, 0);
    step("lu_rs");
    drive(0, 8, 2, 0, 0, 0, 0, 0, 0, 0);
    step("lu_rs_after");
    drive(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    step("lu_zero");
    drive(0, 1, 9, 1, 0, 0, 1, 9, 0, 0);
    step("lu_rt");
    drive(0, 1, 9, 0, 0, 0, 1, 9, 0, 0);
    step("lu_rt_unused");

    drive(0, 8, 0, 0, 0, 1, 1, 8, 0, 1);
    step("branch_beats_stall");

    // HI/LO stall window with use_hilo held.
    drive(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    step("md_issue");
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("hilo_wait");

    // Back-to-back mult/div reload.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("reload_t0");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("reload_t1");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    step("reload_t2");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("reload_tail");

    // Stalled jump is held, then flushed once the hazard clears.
    drive(0, 4, 0, 0, 0, 1, 1, 4, 0, 0);
    step("jump_stalled");
    drive(0, 4, 0, 0, 0, 1, 0, 0, 0, 0);
    step("jump_released");

    // Reset while mult/div is busy abandons the stall.
    drive(0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    step("md_issue2");
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("md_busy2");
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("reset_mid_stall");
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("after_reset_mid_stall");

    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(99) < 2,
            5'($urandom_range(3)), 5'($urandom_range(3)),
            1'($urandom_range(1)), $urandom_range(99) < 40,
            $urandom_range(99) < 15, $urandom_range(99) < 35,
            5'($urandom_range(3)), $urandom_range(99) < 12,
            $urandom_range(99) < 10);
      step("random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
